// File: rtl/csa_tree_accum_if.sv
// Valid/ready stream bundle for csa_tree_accum: operand beats in, sums out.
interface csa_tree_accum_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_OPS = 6,
    parameter int unsigned OUTW    = 11
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_OPS*WIDTH-1:0] in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUTW-1:0]          out_data;
    logic                     out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/csa_tree_accum.sv
// Multi-operand carry-save compressor tree with final CPA and optional
// per-packet accumulation, as a stall-on-full valid/ready stage.
module csa_tree_accum #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_OPS   = 6,
    parameter string       STAGE_REG = "TRUE",
    parameter string       ACCUM     = "FALSE",
    parameter int unsigned ACC_BITS  = 4
) (
    input logic            clk,
    input logic            rst_n,
    csa_tree_accum_if.slave bus
);
    function automatic int unsigned rows_at(int unsigned lvl);
        int unsigned h;
        h = NUM_OPS;
        for (int unsigned i = 0; i < lvl; i++) h = h - h / 3;
        return h;
    endfunction

    function automatic int unsigned tree_depth(int unsigned n);
        int unsigned h;
        int unsigned d;
        h = n;
        d = 0;
        while (h > 2) begin
            h = h - h / 3;
            d = d + 1;
        end
        return d;
    endfunction

    localparam bit          ACC_EN = (ACCUM == "TRUE");
    localparam bit          REG_EN = (STAGE_REG == "TRUE");
    localparam int unsigned OUTW   = WIDTH + $clog2(NUM_OPS) + (ACC_EN ? ACC_BITS : 0);
    localparam int unsigned L      = tree_depth(NUM_OPS);

    logic en;
    assign en           = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;

    // Rows are carried at full OUTW width: the true sum always fits, so
    // dropping carries shifted past the top bit never loses information.
    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int unsigned HI = rows_at(l);
        localparam int unsigned G  = HI / 3;
        localparam int unsigned HO = HI - G;

        logic [OUTW-1:0] r_in  [HI];
        logic [OUTW-1:0] r_nx  [HO];
        logic [OUTW-1:0] r_out [HO];
        logic            v_in, l_in, v_out, l_out;

        if (l == 0) begin : g_src
            for (genvar i = 0; i < HI; i++) begin : g_op
                assign r_in[i] = OUTW'(bus.in_data[i*WIDTH +: WIDTH]);
            end
            assign v_in = bus.in_valid & en;
            assign l_in = bus.in_last;
        end else begin : g_src
            for (genvar i = 0; i < HI; i++) begin : g_op
                assign r_in[i] = g_lvl[l-1].r_out[i];
            end
            assign v_in = g_lvl[l-1].v_out;
            assign l_in = g_lvl[l-1].l_out;
        end

        always_comb begin
            for (int unsigned i = 0; i < HO; i++) r_nx[i] = '0;
            for (int unsigned k = 0; k < G; k++) begin
                r_nx[2*k]   = r_in[3*k] ^ r_in[3*k+1] ^ r_in[3*k+2];
                r_nx[2*k+1] = ((r_in[3*k] & r_in[3*k+1]) |
                               (r_in[3*k] & r_in[3*k+2]) |
                               (r_in[3*k+1] & r_in[3*k+2])) << 1;
            end
            for (int unsigned i = 3*G; i < HI; i++) r_nx[i-G] = r_in[i];
        end

        if (REG_EN) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_out <= 1'b0;
                    l_out <= 1'b0;
                    for (int unsigned i = 0; i < HO; i++) r_out[i] <= '0;
                end else if (en) begin
                    v_out <= v_in;
                    l_out <= l_in;
                    for (int unsigned i = 0; i < HO; i++) r_out[i] <= r_nx[i];
                end
            end
        end else begin : g_comb
            assign v_out = v_in;
            assign l_out = l_in;
            for (genvar i = 0; i < HO; i++) begin : g_pass
                assign r_out[i] = r_nx[i];
            end
        end
    end

    logic [OUTW-1:0] tree_sum;
    logic            t_valid, t_last;
    assign tree_sum = g_lvl[L-1].r_out[0] + g_lvl[L-1].r_out[1];
    assign t_valid  = g_lvl[L-1].v_out;
    assign t_last   = g_lvl[L-1].l_out;

    if (ACC_EN) begin : g_acc
        logic [OUTW-1:0] acc_q, acc_base;
        logic [OUTW:0]   acc_sum;
        logic            ovf_q, ovf_base, first_q;

        // first_q marks that the next valid beat opens a new packet
        always_comb begin
            acc_base = first_q ? '0 : acc_q;
            ovf_base = first_q ? 1'b0 : ovf_q;
            acc_sum  = {1'b0, acc_base} + {1'b0, tree_sum};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q         <= '0;
                ovf_q         <= 1'b0;
                first_q       <= 1'b1;
                bus.out_valid <= 1'b0;
                bus.out_data  <= '0;
                bus.out_ovf   <= 1'b0;
            end else if (en) begin
                bus.out_valid <= t_valid & t_last;
                if (t_valid) begin
                    acc_q   <= acc_sum[OUTW-1:0];
                    ovf_q   <= ovf_base | acc_sum[OUTW];
                    first_q <= t_last;
                    if (t_last) begin
                        bus.out_data <= acc_sum[OUTW-1:0];
                        bus.out_ovf  <= ovf_base | acc_sum[OUTW];
                    end
                end
            end
        end
    end else begin : g_sum
        logic unused_last;
        assign unused_last = t_last;
        assign bus.out_ovf = 1'b0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bus.out_valid <= 1'b0;
                bus.out_data  <= '0;
            end else if (en) begin
                bus.out_valid <= t_valid;
                if (t_valid) bus.out_data <= tree_sum;
            end
        end
    end
endmodule

// File: tb/tb_csa_tree_accum.sv
// Scoreboard bench: three csa_tree_accum configurations share one beat stream;
// a plain-arithmetic model predicts each output, monitors pop and compare.
module tb_csa_tree_accum;
    typedef struct packed {
        logic [14:0] data;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [47:0] in_data;
    logic        in_last;
    logic [2:0]  rdy;
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    int unsigned mode;
    logic        lat_chk;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    longint unsigned acc_tot;
    logic        hold_v [3];
    logic [15:0] hold_d [3];

    csa_tree_accum_if #(.WIDTH(8), .NUM_OPS(6), .OUTW(11)) bp ();
    csa_tree_accum_if #(.WIDTH(8), .NUM_OPS(6), .OUTW(11)) bc ();
    csa_tree_accum_if #(.WIDTH(8), .NUM_OPS(6), .OUTW(15)) ba ();

    csa_tree_accum #(.WIDTH(8), .NUM_OPS(6), .STAGE_REG("TRUE"), .ACCUM("FALSE"), .ACC_BITS(4))
        u_pipe (.clk(clk), .rst_n(rst_n), .bus(bp));
    csa_tree_accum #(.WIDTH(8), .NUM_OPS(6), .STAGE_REG("FALSE"), .ACCUM("FALSE"), .ACC_BITS(4))
        u_comb (.clk(clk), .rst_n(rst_n), .bus(bc));
    csa_tree_accum #(.WIDTH(8), .NUM_OPS(6), .STAGE_REG("TRUE"), .ACCUM("TRUE"), .ACC_BITS(4))
        u_acc (.clk(clk), .rst_n(rst_n), .bus(ba));

    assign bp.in_valid = in_valid;  assign bp.in_data = in_data;  assign bp.in_last = in_last;
    assign bc.in_valid = in_valid;  assign bc.in_data = in_data;  assign bc.in_last = in_last;
    assign ba.in_valid = in_valid;  assign ba.in_data = in_data;  assign ba.in_last = in_last;
    assign bp.out_ready = rdy[0];
    assign bc.out_ready = rdy[1];
    assign ba.out_ready = rdy[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string dname(input int id);
        return (id == 0) ? "pipe" : (id == 1) ? "comb" : "acc";
    endfunction

    function automatic int unsigned lat_of(input int id);
        return (id == 1) ? 1 : 4;
    endfunction

    function automatic int unsigned opsum(input logic [47:0] d);
        int unsigned s;
        s = 0;
        for (int k = 0; k < 6; k++) s += d[k*8 +: 8];
        return s;
    endfunction

    function automatic logic [47:0] rep(input logic [7:0] b);
        return {6{b}};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic ir, input logic ov, input logic ordy,
                       input logic [14:0] od, input logic of);
        exp_t e;
        logic got;
        got = 1'b0;
        e   = '0;
        chk({dname(id), "_in_ready"}, 32'(ir), 32'(!ov || ordy));
        if (hold_v[id]) begin
            chk({dname(id), "_hold_valid"}, 32'(ov), 32'd1);
            chk({dname(id), "_hold_data"}, 32'({od, of}), 32'(hold_d[id]));
        end
        if (ov && ordy) begin
            if (id == 0 && q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
            else if (id == 1 && q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
            else if (id == 2 && q2.size() != 0) begin e = q2.pop_front(); got = 1'b1; end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected: got output %0d, expected none", dname(id), od);
            end else begin
                chk({dname(id), "_data"}, 32'(od), 32'(e.data));
                chk({dname(id), "_ovf"}, 32'(of), 32'(e.ovf));
                if (lat_chk) chk({dname(id), "_latency"}, cyc - e.cyc, lat_of(id));
            end
        end
        hold_v[id] = ov && !ordy;
        hold_d[id] = {od, of};
    endtask

    always @(negedge clk) if (rst_n) mon(0, bp.in_ready, bp.out_valid, bp.out_ready, 15'(bp.out_data), bp.out_ovf);
    always @(negedge clk) if (rst_n) mon(1, bc.in_ready, bc.out_valid, bc.out_ready, 15'(bc.out_data), bc.out_ovf);
    always @(negedge clk) if (rst_n) mon(2, ba.in_ready, ba.out_valid, ba.out_ready, ba.out_data, ba.out_ovf);

    task automatic drive_ready();
        case (mode)
            0: rdy = '1;
            1: rdy = {($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0};
            default: rdy = '0;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 drive_ready();
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [47:0] d, input logic last);
        exp_t        e;
        int unsigned s;
        int unsigned tries;
        tries = 0;
        forever begin
            @(posedge clk);
            #1 drive_ready();
            in_valid = 1'b0;
            #1;
            if (bp.in_ready && bc.in_ready && ba.in_ready) break;
            tries++;
            if (tries > 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck low, expected acceptance");
                return;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        s        = opsum(d);
        e.data   = 15'(s);
        e.ovf    = 1'b0;
        e.cyc    = cyc;
        q0.push_back(e);
        q1.push_back(e);
        acc_tot += s;
        if (last) begin
            e.data = 15'(acc_tot % 64'd32768);
            e.ovf  = (acc_tot >= 64'd32768);
            q2.push_back(e);
            acc_tot = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        rdy      = '1;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        mode     = 0;
        lat_chk  = 1'b1;
        acc_tot  = 0;
        for (int i = 0; i < 3; i++) begin hold_v[i] = 1'b0; hold_d[i] = '0; end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_pipe_valid", 32'(bp.out_valid), 0);  chk("rst_pipe_data", 32'(bp.out_data), 0);
        chk("rst_pipe_ovf", 32'(bp.out_ovf), 0);      chk("rst_pipe_ready", 32'(bp.in_ready), 1);
        chk("rst_comb_valid", 32'(bc.out_valid), 0);  chk("rst_comb_data", 32'(bc.out_data), 0);
        chk("rst_comb_ovf", 32'(bc.out_ovf), 0);      chk("rst_comb_ready", 32'(bc.in_ready), 1);
        chk("rst_acc_valid", 32'(ba.out_valid), 0);   chk("rst_acc_data", 32'(ba.out_data), 0);
        chk("rst_acc_ovf", 32'(ba.out_ovf), 0);       chk("rst_acc_ready", 32'(ba.in_ready), 1);

        // single all-0xFF beat, then back-to-back beats
        send(rep(8'hFF), 1'b1);
        idle(6);
        send(48'h06_05_04_03_02_01, 1'b1);
        send(rep(8'h80), 1'b1);
        idle(6);

        // three-beat packet, then single-beat packet of ones
        send(rep(8'hFF), 1'b0);
        send(rep(8'hFF), 1'b0);
        send(rep(8'hFF), 1'b1);
        send(rep(8'h01), 1'b1);
        idle(6);

        // 22-beat packet that wraps the accumulator, then a zero packet
        for (int i = 0; i < 21; i++) send(rep(8'hFF), 1'b0);
        send(rep(8'hFF), 1'b1);
        send(48'h0, 1'b1);
        idle(6);

        // backpressure: results pile up behind a 5-cycle stall
        lat_chk = 1'b0;
        for (int i = 0; i < 3; i++) send({16'($urandom), 32'($urandom)}, 1'b1);
        mode = 2;
        idle(5);
        mode = 0;
        idle(8);

        // reset in the middle of a 3-beat packet
        send(rep(8'hFF), 1'b0);
        send(rep(8'h7F), 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_pipe_valid", 32'(bp.out_valid), 0);  chk("midrst_pipe_data", 32'(bp.out_data), 0);
        chk("midrst_comb_valid", 32'(bc.out_valid), 0);  chk("midrst_comb_data", 32'(bc.out_data), 0);
        chk("midrst_acc_valid", 32'(ba.out_valid), 0);   chk("midrst_acc_data", 32'(ba.out_data), 0);
        in_valid = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        acc_tot = 0;
        for (int i = 0; i < 3; i++) hold_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        lat_chk = 1'b1;
        send(rep(8'hFF), 1'b1);
        idle(6);

        // randomized traffic with random gaps and per-output backpressure
        lat_chk = 1'b0;
        mode    = 1;
        for (int i = 0; i < 300; i++) begin
            send({16'($urandom), 32'($urandom)}, ($urandom % 4) == 0);
            if (($urandom % 5) == 0) idle(int'($urandom % 3));
        end
        send({16'($urandom), 32'($urandom)}, 1'b1);
        mode = 0;
        idle(20);

        chk("pipe_drained", q0.size(), 0);
        chk("comb_drained", q1.size(), 0);
        chk("acc_drained", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
